// File: rtl/cpu_bus_initiator.sv
// ---------------------------------------------------------------------------
// cpu_bus_initiator
//
// Synchronous 68030-style bus-cycle initiator with dynamic bus sizing. One
// internal request (address, 1..4 byte operand, direction) is broken into as
// many asynchronous bus cycles as the responding port width requires. Each
// cycle drives A/SIZ/RnW (and write data), asserts /AS and /DS, and ends on a
// synchronized /DSACKx or /BERR.
//
// Optional feature:
//   CPU_BUS_INITIATOR_TIMEOUT_EN - when defined, a WAIT-state cycle counter
//   aborts a bus cycle with an error after TIMEOUT_CYCLES clocks.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (accept on valid & ready)
//   req_rnw, req_addr,        direction, byte address,
//   req_size, req_wdata       size (01=1,10=2,11=3,00=4), right-justified data
//   rsp_valid, rsp_rdata,     one-cycle completion pulse, right-justified
//   rsp_err                   read data, error qualifier
//   nAS, nDS, RnW, SIZ, A     bus control / address outputs
//   D_out, D_oe, D_in         data bus (split), drive enable
//   nDSACK0, nDSACK1, nBERR   asynchronous responder inputs
// ---------------------------------------------------------------------------
module cpu_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        nAS,
    output logic        nDS,
    output logic        RnW,
    output logic [1:0]  SIZ,
    output logic [31:0] A,
    output logic [31:0] D_out,
    output logic        D_oe,
    input  logic [31:0] D_in,
    input  logic        nDSACK0,
    input  logic        nDSACK1,
    input  logic        nBERR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_TERM   = 3'd4;
    localparam logic [2:0] S_RECOV  = 3'd5;

    // Synchronizer stages, bit order {nBERR, nDSACK1, nDSACK0}; idle high.
    logic [2:0]  sync1_q, sync2_q;
    logic        ack0, ack1, berr;

    logic [2:0]  state_q, state_d;
    logic        rnw_q, rnw_d;
    logic [31:0] a_q, a_d;          // current byte address
    logic [2:0]  rem_q, rem_d;      // untransferred bytes
    logic [31:0] wbuf_q, wbuf_d;    // remaining write bytes, P0 in [31:24]
    logic [31:0] rd_q, rd_d;        // read bytes so far, right-justified
    logic        err_q, err_d;
    logic [2:0]  pw_q, pw_d;        // port width of the terminating cycle

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        nas_q, nas_d;
    logic        nds_q, nds_d;
    logic        rnw_out_q, rnw_out_d;
    logic [1:0]  siz_q, siz_d;
    logic [31:0] a_out_q, a_out_d;
    logic [31:0] dout_q, dout_d;
    logic        doe_q, doe_d;

    logic [2:0]  req_bytes;
    logic [1:0]  off;               // a mod port width
    logic [2:0]  room;              // port width - off
    logic [2:0]  xfer;              // bytes moved by this cycle
    logic [1:0]  lane;
    logic [31:0] cap;               // captured read bytes, right-justified

`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign ack0 = ~sync2_q[0];
    assign ack1 = ~sync2_q[1];
    assign berr = ~sync2_q[2];

    // Lane k carries P(k-off) when that byte is still pending. Lane 0 always
    // carries P0 and lane 1 carries P0 or P1, so 8- and 16-bit ports, which
    // only look at the upper lanes, see the right byte at any alignment.
    function automatic logic [31:0] write_lanes(input logic [1:0]  o,
                                                input logic [2:0]  rem,
                                                input logic [31:0] p);
        logic [31:0] d;
        logic [1:0]  k2;
        logic [1:0]  idx;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            k2  = 2'(k);
            idx = k2 - o;
            if (k2 >= o && {1'b0, idx} < rem)
                d[{~k2, 3'b000} +: 8] = p[{~idx, 3'b000} +: 8];
        end
        d[31:24] = p[31:24];
        d[23:16] = o[0] ? p[31:24] : p[23:16];
        return d;
    endfunction

    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        a_d         = a_q;
        rem_d       = rem_q;
        wbuf_d      = wbuf_q;
        rd_d        = rd_q;
        err_d       = err_q;
        pw_d        = pw_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        nas_d       = nas_q;
        nds_d       = nds_q;
        rnw_out_d   = rnw_out_q;
        siz_d       = siz_q;
        a_out_d     = a_out_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        req_bytes = (req_size == 2'b00) ? 3'd4 : {1'b0, req_size};
        off       = a_q[1:0] & (pw_q[1:0] - 2'd1);
        room      = pw_q - {1'b0, off};
        xfer      = (rem_q < room) ? rem_q : room;

        // Transfer byte j comes from lane off+j; lane 0 is D31:24.
        cap  = '0;
        lane = '0;
        for (int j = 0; j < 4; j++) begin
            lane = off + 2'(j);
            if (3'(j) < xfer)
                cap = {cap[23:0], D_in[{~lane, 3'b000} +: 8]};
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rnw_d       = req_rnw;
                    a_d         = req_addr;
                    rem_d       = req_bytes;
                    wbuf_d      = req_wdata << {3'd4 - req_bytes, 3'b000};
                    rd_d        = '0;
                    err_d       = 1'b0;
                    req_ready_d = 1'b0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                nas_d   = 1'b0;
                nds_d   = ~rnw_q;       // reads strobe /DS with /AS
                state_d = S_STROBE;
            end
            S_STROBE: begin
                nds_d   = 1'b0;         // writes strobe /DS one clock later
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (berr) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else if (ack0 || ack1) begin
                    pw_d    = (ack0 && ack1) ? 3'd4 : (ack1 ? 3'd2 : 3'd1);
                    state_d = S_TERM;
                end
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_TERM: begin
                // An errored cycle moves no data; the rest is abandoned.
                if (!err_q) begin
                    if (rnw_q)
                        rd_d = (rd_q << {xfer, 3'b000}) | cap;
                    wbuf_d = wbuf_q << {xfer, 3'b000};
                    a_d    = a_q + {29'd0, xfer};
                    rem_d  = rem_q - xfer;
                end
                nas_d   = 1'b1;
                nds_d   = 1'b1;
                doe_d   = 1'b0;
                state_d = S_RECOV;
            end
            S_RECOV: begin
                if (!ack0 && !ack1 && !berr) begin
                    if (rem_q != 3'd0 && !err_q) begin
                        state_d = S_ADDR;
                    end else begin
                        // Left-align partial data to its operand position.
                        rsp_rdata_d = rd_q << {rem_q, 3'b000};
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_q;
                        req_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address phase outputs are registered on entry to ADDR, so they
        // lead /AS by one clock.
        if (state_d == S_ADDR) begin
            a_out_d   = a_d;
            siz_d     = rem_d[1:0];
            rnw_out_d = rnw_d;
            dout_d    = rnw_d ? 32'd0 : write_lanes(a_d[1:0], rem_d, wbuf_d);
            doe_d     = ~rnw_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            state_q     <= S_IDLE;
            rnw_q       <= 1'b1;
            a_q         <= '0;
            rem_q       <= '0;
            wbuf_q      <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            pw_q        <= 3'd1;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            nas_q       <= 1'b1;
            nds_q       <= 1'b1;
            rnw_out_q   <= 1'b1;
            siz_q       <= 2'b00;
            a_out_q     <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
        end else begin
            sync1_q     <= {nBERR, nDSACK1, nDSACK0};
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            a_q         <= a_d;
            rem_q       <= rem_d;
            wbuf_q      <= wbuf_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            pw_q        <= pw_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            nas_q       <= nas_d;
            nds_q       <= nds_d;
            rnw_out_q   <= rnw_out_d;
            siz_q       <= siz_d;
            a_out_q     <= a_out_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
        end
    end

`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign nAS       = nas_q;
    assign nDS       = nds_q;
    assign RnW       = rnw_out_q;
    assign SIZ       = siz_q;
    assign A         = a_out_q;
    assign D_out     = dout_q;
    assign D_oe      = doe_q;

endmodule

// File: doc/cpu_bus_initiator.md
# cpu_bus_initiator

Synchronous 68030-style bus-cycle initiator. It turns one internal request (address, size, direction, data) into one or more asynchronous bus cycles with dynamic bus sizing: it drives /AS, /DS, R/W, SIZ and A, then waits for /DSACK0-1 or /BERR. It is the master-side counterpart to the board's DRAM and peripheral responders. It serves as the bus engine for DMA and bring-up test logic sharing the 68030 bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max CLK cycles in WAIT before a cycle is aborted as an error (effective only with the timeout feature, see Configuration).

Ports:
- CLK  in  1  bus clock
- nRST  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  initiator idle; request accepted when req_valid & req_ready
- req_rnw  in  1  1=read, 0=write
- req_addr  in  32  byte address
- req_size  in  2  operand bytes: 01=1, 10=2, 11=3, 00=4
- req_wdata  in  32  write operand, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read operand, right-justified, zero-filled
- rsp_err  out  1  qualifies rsp_valid: bus error or timeout
- nAS, nDS  out  1  address/data strobes
- RnW  out  1  bus direction
- SIZ  out  2  remaining-bytes encoding, same as req_size
- A  out  32  current cycle address
- D_out  out  32  write data
- D_oe  out  1  data bus drive enable
- D_in  in  32  read data
- nDSACK0, nDSACK1, nBERR  in  1  asynchronous responder inputs

## Operation
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, nAS=1, nDS=1, RnW=1, SIZ=00, A=0, D_out=0, D_oe=0, state IDLE, byte counter 0.
- nDSACK0, nDSACK1 and nBERR each pass through a 2-flop synchronizer; all FSM decisions use the synchronized values.
- Operand bytes P0..Pn-1 are stored MSB-first. rem is the number of untransferred bytes; a is the current address.
- FSM:
  - IDLE: on accept, latch the request, rem=size, a=addr, go to ADDR.
  - ADDR: drive A=a, SIZ=enc(rem), RnW, and D_out/D_oe for writes; nAS=1. Go to STROBE.
  - STROBE: nAS=0; nDS=0 for reads only. Go to WAIT.
  - WAIT: nDS=0 for writes. Evaluate in priority order:
    - BERR sync asserted: go to TERM with error.
    - Any DSACK sync asserted: go to TERM.
    - Otherwise count cycles.
  - TERM:
    - Port width: both DSACKs=4 bytes, DSACK1 only=2, DSACK0 only=1.
    - o = a mod pb; n = min(rem, pb-o).
    - Read: capture transfer byte j from D_in lane o+j, where lane0=D31:24.
    - Update a+=n, rem-=n. Negate nAS/nDS, D_oe=0. Go to RECOV.
  - RECOV: wait until both DSACK sync and BERR sync are negated. Then, if rem>0 and no error, go to ADDR; else pulse rsp_valid and go to IDLE.
- Write lanes:
  - lane k = P(k - a[1:0]) for valid indices;
  - then override lane0 = P0, and lane1 = P0 if a[0] else P1.
  - This is correct for 8-, 16- and 32-bit ports.
- On error, rsp_rdata holds the bytes captured so far (undefined bytes = 0); the remaining bytes are abandoned.
- Simultaneous BERR and DSACK: BERR wins and no data is captured.
- nRST asserted mid-cycle: all outputs return to reset values immediately and no response is emitted.

## Timing
- req_ready falls the cycle after accept and rises in the cycle rsp_valid pulses.
- Single 32-bit-port cycle, with responder DSACK asserted k cycles after nAS falls:
  - rsp_valid = accept + 4 + k + 2 (sync) + RECOV wait.
  - Minimum 8 cycles with k=0 and an immediate DSACK release.
- Minimum one CLK with nAS=1 between consecutive sized cycles (TERM/RECOV to STROBE spans ≥2 cycles).
- D_oe asserts in ADDR, one cycle before nAS, and drops in TERM together with nAS.

## Configuration
- CPU_BUS_INITIATOR_TIMEOUT_EN defined: the WAIT counter is compiled in. When the count reaches TIMEOUT_CYCLES without DSACK/BERR, the FSM goes to TERM with error, and rsp_err=1 on rsp_valid.
- Undefined: no counter; WAIT holds indefinitely until DSACK or BERR.

## Test plan
- Long read, addr 0x1000, responder gives both DSACKs, D_in=0xDEADBEEF -> one bus cycle, SIZ=00, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Long write 0x11223344 to addr 0x2002 on a 32-bit port -> two cycles: A=0x2002 SIZ=00 lanes2-3=11,22; then A=0x2004 SIZ=10 lanes0-1=33,44.
- Long read on an 8-bit port (DSACK0 only), bytes AA,BB,CC,DD on D31:24 -> four cycles, SIZ 00,11,10,01, rsp_rdata=0xAABBCCDD.
- Word read at addr 0x3001 on a 16-bit port -> two cycles; first byte captured from lane1, second from lane0.
- BERR asserted alongside DSACK on a read -> rsp_valid with rsp_err=1, no further cycles, nAS=1.
- With TIMEOUT_EN and TIMEOUT_CYCLES=10, no responder -> rsp_err=1 after ~10 WAIT cycles. Without the macro, the FSM remains in WAIT for 1000 cycles. nRST pulsed mid-WAIT -> nAS=1, req_ready=1.
